// File: rtl/operand_issue_stage.sv
// LEGv8 decode/issue stage: 32x64 register file with write-through bypass,
// decode of R/D/CB formats, and an ID/EX register with stall, flush and stall-time operand refresh.
module operand_issue_stage #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned REG_CNT = 32,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              Instr_Valid,
    input  logic [31:0]       Instruction,
    output logic              Instr_Ready,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              WB_En,
    input  logic [ADDR_W-1:0] WB_Reg,
    input  logic [DATA_W-1:0] WB_Data,
    output logic              EX_Valid,
    output logic [1:0]        ALUOp,
    output logic [10:0]       Opcode,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [ADDR_W-1:0] Rd,
    output logic              Illegal
);

    localparam int unsigned  DT_W   = 9;
    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(REG_CNT - 1);

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LIVE,
        ST_HELD
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   rf_q [REG_CNT];
    logic [DATA_W-1:0]   rf_d [REG_CNT];

    logic                ex_valid_q, ex_valid_d;
    logic [1:0]          aluop_q, aluop_d;
    logic [10:0]         opcode_q, opcode_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic                illegal_q, illegal_d;
    logic [ADDR_W-1:0]   src_a_q, src_a_d;
    logic [ADDR_W-1:0]   src_b_q, src_b_d;
    logic                a_reg_q, a_reg_d;
    logic                b_reg_q, b_reg_d;

    logic                accept;
    logic [10:0]         dec_op;
    logic                dec_legal;
    logic [1:0]          dec_aluop;
    logic                dec_a_reg, dec_b_reg;
    logic [ADDR_W-1:0]   dec_src_a, dec_src_b;
    logic [DATA_W-1:0]   dec_imm, rd_a, rd_b, dec_a, dec_b;
    logic                unused_fields;

    assign unused_fields = ^Instruction[11:10];
    assign Instr_Ready   = Reset_n & ~Stall & ~Flush;
    assign accept        = Instr_Valid & Instr_Ready;

    // Register file next value; X31 writes are dropped.
    always_comb begin
        rf_d = rf_q;
        if (WB_En && (WB_Reg != XZR)) begin
            rf_d[WB_Reg] = WB_Data;
        end
    end

    // Instruction decode and operand read with write-back bypass.
    always_comb begin
        dec_op    = Instruction[31:21];
        dec_legal = 1'b0;
        dec_aluop = 2'b00;
        dec_a_reg = 1'b0;
        dec_b_reg = 1'b0;
        dec_src_a = Instruction[9:5];
        dec_src_b = Instruction[20:16];
        dec_imm   = DATA_W'($signed(Instruction[20:12]));
        if ((dec_op == OP_ADD) || (dec_op == OP_SUB) ||
            (dec_op == OP_AND) || (dec_op == OP_ORR)) begin
            dec_legal = 1'b1;
            dec_aluop = 2'b10;
            dec_a_reg = 1'b1;
            dec_b_reg = 1'b1;
        end else if ((dec_op == OP_LDUR) || (dec_op == OP_STUR)) begin
            dec_legal = 1'b1;
            dec_aluop = 2'b00;
            dec_a_reg = 1'b1;
        end else if (dec_op[10:3] == OP_CBZ) begin
            dec_legal = 1'b1;
            dec_aluop = 2'b01;
            dec_b_reg = 1'b1;
            dec_src_b = Instruction[4:0];
        end

        if (dec_src_a == XZR) begin
            rd_a = '0;
        end else if (WB_En && (WB_Reg == dec_src_a)) begin
            rd_a = WB_Data;
        end else begin
            rd_a = rf_q[dec_src_a];
        end

        if (dec_src_b == XZR) begin
            rd_b = '0;
        end else if (WB_En && (WB_Reg == dec_src_b)) begin
            rd_b = WB_Data;
        end else begin
            rd_b = rf_q[dec_src_b];
        end

        dec_a = dec_a_reg ? rd_a : '0;
        dec_b = dec_b_reg ? rd_b : dec_imm;
    end

    // ID/EX next state: Flush > Stall > Accept > bubble.
    always_comb begin
        state_d   = state_q;
        aluop_d   = aluop_q;
        opcode_d  = opcode_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        src_a_d   = src_a_q;
        src_b_d   = src_b_q;
        a_reg_d   = a_reg_q;
        b_reg_d   = b_reg_q;
        illegal_d = 1'b0;

        if (Flush) begin
            state_d = ST_EMPTY;
        end else if (Stall) begin
            if (state_q != ST_EMPTY) begin
                state_d = ST_HELD;
                // A held operand tracks writes to its source register.
                if (WB_En && (WB_Reg != XZR)) begin
                    if (a_reg_q && (WB_Reg == src_a_q)) a_d = WB_Data;
                    if (b_reg_q && (WB_Reg == src_b_q)) b_d = WB_Data;
                end
            end
        end else if (accept) begin
            if (dec_legal) begin
                state_d  = ST_LIVE;
                aluop_d  = dec_aluop;
                opcode_d = dec_op;
                a_d      = dec_a;
                b_d      = dec_b;
                rd_d     = Instruction[4:0];
                src_a_d  = dec_src_a;
                src_b_d  = dec_src_b;
                a_reg_d  = dec_a_reg;
                b_reg_d  = dec_b_reg;
            end else begin
                state_d   = ST_EMPTY;
                illegal_d = 1'b1;
            end
        end else begin
            state_d = ST_EMPTY;
        end

        ex_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q    <= ST_EMPTY;
            ex_valid_q <= 1'b0;
            aluop_q    <= '0;
            opcode_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            illegal_q  <= 1'b0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            a_reg_q    <= 1'b0;
            b_reg_q    <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ex_valid_q <= ex_valid_d;
            aluop_q    <= aluop_d;
            opcode_q   <= opcode_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rd_q       <= rd_d;
            illegal_q  <= illegal_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            a_reg_q    <= a_reg_d;
            b_reg_q    <= b_reg_d;
            rf_q       <= rf_d;
        end
    end

    assign EX_Valid = ex_valid_q;
    assign ALUOp    = aluop_q;
    assign Opcode   = opcode_q;
    assign A        = a_q;
    assign B        = b_q;
    assign Rd       = rd_q;
    assign Illegal  = illegal_q;

endmodule
